// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and default sizes
// Provides tx_feed_state_t plus UART_WIDTH / TX_FIFO_DEPTH defaults.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} tx_feed_state_t;
  localparam int UART_WIDTH = 8;
  localparam int TX_FIFO_DEPTH = 16;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count/full/empty/almost_full and flush
// Ports: clk, reset (async high); wr_en/wr_data push; rd_en pops; flush empties;
// rd_data is the head entry; full, almost_full, empty, count report fill level.
module sync_fifo import uart_pkg::*; #(
  parameter int WIDTH_SIZE = UART_WIDTH,
  parameter int DEPTH = TX_FIFO_DEPTH,
  parameter int AF_THRESH = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [WIDTH_SIZE-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic                    flush,
  output logic [WIDTH_SIZE-1:0]   rd_data,
  output logic                    full,
  output logic                    almost_full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH_SIZE-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, w_count_n;
  logic r_full, r_af, r_empty;
  logic w_push, w_pop;
  // full/empty are the registered pre-edge flags, so a write while full is dropped even alongside a pop
  assign w_push = wr_en && !r_full && !flush;
  assign w_pop = rd_en && !r_empty && !flush;
  assign w_count_n = flush ? '0 : r_count + CW'(w_push) - CW'(w_pop);
  assign rd_data = r_mem[r_rd_ptr];
  assign full = r_full;
  assign almost_full = r_af;
  assign empty = r_empty;
  assign count = r_count;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_full <= 1'b0;
      r_af <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wr_ptr <= flush ? '0 : r_wr_ptr + AW'(w_push);
      r_rd_ptr <= flush ? '0 : r_rd_ptr + AW'(w_pop);
      r_count <= w_count_n;
      r_full <= w_count_n == CW'(DEPTH);
      r_af <= w_count_n >= CW'(AF_THRESH);
      r_empty <= w_count_n == '0;
    end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers host bytes and launches them one frame at a time into the UART transmitter
// Ports: clk, reset (async high); wr_en/wr_data host writes; flush, clear_ovf controls;
// full, almost_full, empty, count, overflow status; ready from UART; Tx_valid/input_tx to UART.
module uart_tx_feeder import uart_pkg::*; #(
  parameter int WIDTH_SIZE = UART_WIDTH,
  parameter int DEPTH = TX_FIFO_DEPTH,
  parameter int AF_THRESH = 12,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [WIDTH_SIZE-1:0]   wr_data,
  input  logic                    flush,
  input  logic                    clear_ovf,
  output logic                    full,
  output logic                    almost_full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  input  logic                    ready,
  output logic                    Tx_valid,
  output logic [WIDTH_SIZE-1:0]   input_tx
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  tx_feed_state_t r_state;
  logic [TW-1:0] r_timer;
  logic [WIDTH_SIZE-1:0] r_input_tx, w_head;
  logic r_tx_valid, r_overflow;
  logic w_launch, w_drop;
  assign w_launch = r_state == IDLE && !empty && ready && !flush;
  assign w_drop = wr_en && full && !flush;
  assign Tx_valid = r_tx_valid;
  assign input_tx = r_input_tx;
  assign overflow = r_overflow;
  sync_fifo #(.WIDTH_SIZE(WIDTH_SIZE), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) u_fifo (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(w_launch),
    .flush(flush), .rd_data(w_head), .full(full), .almost_full(almost_full),
    .empty(empty), .count(count)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_input_tx <= '0;
      r_tx_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_drop ? 1'b1 : clear_ovf ? 1'b0 : r_overflow;
      r_tx_valid <= w_launch;
      case (r_state)
        IDLE: if (w_launch) begin
          r_state <= LAUNCH;
          r_input_tx <= w_head;
        end
        LAUNCH: begin
          r_state <= WAIT_BUSY;
          r_timer <= '0;
        end
        // a UART that never drops ready is assumed to have missed or finished the frame
        WAIT_BUSY: if (!ready) r_state <= WAIT_DONE;
          else if (r_timer == TW'(BUSY_TIMEOUT - 1)) r_state <= IDLE;
          else r_timer <= r_timer + TW'(1);
        WAIT_DONE: if (ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: scoreboard bench for uart_tx_feeder with a behavioural FIFO/UART model
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  logic clk = 0, reset = 0, wr_en = 0, flush = 0, clear_ovf = 0, ready = 1;
  logic [7:0] wr_data = 0;
  logic full, almost_full, empty, overflow, tx_valid_w;
  logic [4:0] count;
  logic [7:0] input_tx;
  int checks = 0, errors = 0, cyc_n = 0, wr_cyc = 0, w0 = 0, k = 0;
  logic [7:0] mq [$];
  int lq [$];
  logic ovf_m = 0, uart_auto = 0, ready_lvl = 1, prev_tv = 0;

  uart_tx_feeder dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .clear_ovf(clear_ovf), .full(full), .almost_full(almost_full), .empty(empty),
    .count(count), .overflow(overflow), .ready(ready), .Tx_valid(tx_valid_w),
    .input_tx(input_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc_n);
    end
  endtask

  task automatic cyc(input logic we, input logic [7:0] d, input logic fl, input logic co);
    logic drop;
    wr_en = we; wr_data = d; flush = fl; clear_ovf = co;
    @(posedge clk);
    drop = we && !fl && mq.size() >= DEPTH;
    if (fl) mq.delete();
    else if (we && !drop) mq.push_back(d);
    ovf_m = drop ? 1'b1 : co ? 1'b0 : ovf_m;
    #1;
    wr_cyc = cyc_n;
    wr_en = 0; flush = 0; clear_ovf = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 8'h00, 0, 0);
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while (mq.size() > 0 && n < limit) begin
      idle(1);
      n++;
    end
    chk(name, mq.size(), 0);
  endtask

  // UART model: either holds ready at ready_lvl, or drops it for 20 cycles after each pulse
  initial forever begin
    @(negedge clk);
    if (uart_auto) begin
      if (tx_valid_w) begin
        ready = 0;
        repeat (20) @(negedge clk);
        ready = 1;
      end
    end else ready = ready_lvl;
  end

  // monitor: every launch must deliver the oldest accepted byte; status must match the model
  initial forever begin
    @(negedge clk);
    if (tx_valid_w) begin
      lq.push_back(cyc_n);
      chk("tx_pulse_width", prev_tv, 0);
      chk("launch_expected", mq.size() > 0, 1);
      if (mq.size() > 0) chk("tx_byte", input_tx, mq.pop_front());
    end
    prev_tv = tx_valid_w;
    chk("count", count, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTH);
    chk("almost_full", almost_full, mq.size() >= AF);
    chk("overflow", overflow, ovf_m);
  end

  initial begin
    #1 reset = 1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_tx_valid", tx_valid_w, 0);
    chk("rst_input_tx", input_tx, 0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    // single byte
    uart_auto = 0; ready_lvl = 1;
    idle(2); lq.delete();
    cyc(1, 8'hA5, 0, 0); w0 = wr_cyc;
    idle(3);
    chk("single_launches", lq.size(), 1);
    if (lq.size() > 0) chk("single_latency", lq[0], w0 + 1);
    chk("single_hold", input_tx, 8'hA5);
    // burst with handshaking UART
    idle(6); uart_auto = 1; lq.delete();
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 8'(i), 0, 0);
      if (i == 1) w0 = wr_cyc;
    end
    drain("burst_drain", 200);
    idle(25);
    chk("burst_launches", lq.size(), 5);
    if (lq.size() == 5) begin
      chk("burst_first", lq[0], w0 + 1);
      for (int i = 1; i < 5; i++) chk("burst_gap", lq[i] - lq[i-1], 22);
    end
    chk("burst_empty", empty, 1);
    // fill and overflow with UART busy
    uart_auto = 0; ready_lvl = 0;
    idle(2); lq.delete();
    for (int i = 1; i <= 17; i++) begin
      cyc(1, 8'($urandom), 0, 0);
      chk("fill_af", almost_full, i >= AF);
      chk("fill_full", full, i >= DEPTH);
      chk("fill_ovf", overflow, i > DEPTH);
    end
    chk("fill_count", count, DEPTH);
    cyc(1, 8'($urandom), 0, 1);
    chk("ovf_set_wins", overflow, 1);
    cyc(0, 8'h00, 0, 1);
    chk("ovf_cleared", overflow, 0);
    cyc(1, 8'($urandom), 1, 0);
    chk("flush_write_no_ovf", overflow, 0);
    chk("flush_write_count", count, 0);
    chk("fill_no_launch", lq.size(), 0);
    // flush mid-frame
    ready_lvl = 1; idle(1); uart_auto = 1;
    idle(3); lq.delete();
    for (int i = 0; i < 4; i++) cyc(1, 8'($urandom), 0, 0);
    idle(8);
    cyc(0, 8'h00, 1, 0);
    chk("flush_count", count, 0);
    idle(40);
    chk("flush_launches", lq.size(), 1);
    chk("flush_ready_back", ready, 1);
    // timeout: UART never drops ready
    uart_auto = 0; ready_lvl = 1;
    idle(3); lq.delete();
    cyc(1, 8'($urandom), 0, 0); w0 = wr_cyc;
    cyc(1, 8'($urandom), 0, 0);
    idle(12);
    chk("timeout_launches", lq.size(), 2);
    if (lq.size() == 2) begin
      chk("timeout_first", lq[0], w0 + 1);
      chk("timeout_gap", lq[1] - lq[0], 6);
    end
    // random traffic: wraps pointers, provokes overflows and clears
    lq.delete();
    for (int i = 0; i < 150; i++)
      cyc($urandom_range(0, 9) < 3, 8'($urandom), 0, $urandom_range(0, 19) == 0);
    drain("random_drain", 200);
    cyc(0, 8'h00, 0, 1);
    idle(8);
    // async reset while a frame is launching and bytes are queued
    ready_lvl = 0; idle(2); lq.delete();
    for (int i = 0; i < 3; i++) cyc(1, 8'($urandom), 0, 0);
    ready_lvl = 1;
    k = 0;
    while (!tx_valid_w && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("pre_rst_tx_valid", tx_valid_w, 1);
    #2 reset = 1;
    mq.delete(); ovf_m = 0;
    #1;
    chk("arst_tx_valid", tx_valid_w, 0);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_input_tx", input_tx, 0);
    chk("arst_ovf", overflow, 0);
    @(posedge clk); @(posedge clk);
    #1 reset = 0;
    idle(15);
    chk("arst_no_launch", lq.size(), 1);
    cyc(1, 8'h3C, 0, 0);
    idle(8);
    chk("arst_new_launch", lq.size(), 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_n);
    $fatal(1);
  end
endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Transmit-side buffer and launcher placed directly upstream of the UART transmitter. It accepts bytes from the host at full clock rate into a small synchronous FIFO. It then hands them to the UART one frame at a time over the UART's `Tx_valid` / `input_tx` / `ready` interface, so the host never has to poll `ready` itself. It also reports fill level and a sticky overflow flag.

## Interface
- `WIDTH_SIZE`, default 8: data width; must match the UART's `WIDTH_SIZE`.
- `DEPTH`, default 16: FIFO entries; power of two, at least 2.
- `AF_THRESH`, default 12: `almost_full` asserts when count ≥ `AF_THRESH`.
- `BUSY_TIMEOUT`, default 4: cycles to wait for the UART to drop `ready` after a launch.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `wr_en`  in  1: host write strobe.
- `wr_data`  in  `WIDTH_SIZE`: host byte.
- `flush`  in  1: discard all queued bytes.
- `clear_ovf`  in  1: clear the sticky overflow flag.
- `full`  out  1: count == `DEPTH`.
- `almost_full`  out  1: count ≥ `AF_THRESH`.
- `empty`  out  1: count == 0.
- `count`  out  $clog2(`DEPTH`)+1: entries held.
- `overflow`  out  1: sticky; a write was dropped.
- `ready`  in  1: UART idle, able to accept a frame.
- `Tx_valid`  out  1: one-cycle launch pulse to the UART.
- `input_tx`  out  `WIDTH_SIZE`: byte to the UART; held stable between launches.

## Operation
- **Reset values:** state IDLE, pointers 0, `count`=0, `empty`=1, `full`=0, `almost_full`=0, `overflow`=0, `Tx_valid`=0, `input_tx`=0.
- **Push:** on `wr_en && !full` at an edge, `wr_data` is stored and `count` increments.
  - `full` is the registered pre-edge value.
  - A write while full is dropped even if a pop happens on the same edge.
  - A dropped write sets `overflow`.
- **Pop:** occurs on the edge where the FSM leaves IDLE for LAUNCH.
  - The head byte is loaded into the `input_tx` register and the read pointer advances.
  - A simultaneous push and pop leaves `count` unchanged.
- **Pointers:** wrap modulo `DEPTH`. `count` is held explicitly (no extra pointer bit) and saturates logically at `DEPTH`.
- **overflow:** set on a dropped write, cleared by `clear_ovf`. If both occur on the same edge, set wins.
- **flush:** on an edge with `flush`=1, pointers and `count` go to 0.
  - A `wr_en` on the same edge is ignored; `overflow` is not set by it.
  - A frame already launched (LAUNCH, WAIT_BUSY, WAIT_DONE) continues unaffected.
  - A pop on the flush edge is suppressed, and the FSM stays in IDLE.
- **FSM states:**
  - IDLE → LAUNCH when `!empty && ready && !flush`.
  - LAUNCH → WAIT_BUSY unconditionally after 1 cycle. `Tx_valid`=1 only in LAUNCH.
  - WAIT_BUSY → WAIT_DONE when `ready`=0.
  - WAIT_BUSY → IDLE when `ready` stays 1 for `BUSY_TIMEOUT` cycles (UART missed the pulse or finished instantly). Frame counted as sent; no retry.
  - WAIT_DONE → IDLE when `ready`=1.
- **Reset mid-operation:** all queued and in-flight state is discarded immediately. `Tx_valid` drops asynchronously.

## Timing
- A write on edge E0 into an empty FIFO, with `ready`=1, gives `Tx_valid`=1 during E1–E2 with `input_tx` = that byte. Write-to-launch latency is 1 cycle.
- `Tx_valid` is always exactly one cycle wide. There is at most one launch per UART `ready` low→high cycle.
- Back-to-back frames: the next launch comes no earlier than 1 cycle after `ready` returns high. WAIT_DONE→IDLE takes one edge and IDLE→LAUNCH takes the next.
- `count`, `full`, `empty` and `almost_full` are registered and update on the edge of the push or pop.
- `input_tx` changes only on the edge entering LAUNCH.

## Structure
- Shared package `uart_pkg` holds:
  - `tx_feed_state_t` enum: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - Default constants `UART_WIDTH`=8 and `TX_FIFO_DEPTH`=16.
- Sub-module `sync_fifo`: storage, pointers, count, full/empty/almost_full, flush. It is reusable later for the RX side.
- Top level `uart_tx_feeder` holds the FSM, the timeout counter, the `input_tx` register and the `overflow` flag.

## Test plan
- **Single byte:** reset, keep `ready`=1, write 8'hA5. Required: `Tx_valid` is a 1-cycle pulse in the cycle after the write edge, `input_tx`=8'hA5, `count` goes 0→1→0.
- **Burst and ordering:** write 8'h01..8'h05 back-to-back. Model the UART: `ready` low 20 cycles after each pulse. Required: launches in order 01,02,03,04,05, one per `ready` rise, `empty`=1 at the end.
- **Fill and overflow:** hold `ready`=0 and write 17 bytes. Required:
  - `almost_full` rises when the 12th write is accepted.
  - `full` rises at 16.
  - The 17th write is dropped and `overflow`=1.
  - `clear_ovf` clears `overflow`; a same-cycle dropped write keeps it at 1.
- **Flush mid-frame:** queue 4 bytes, flush during WAIT_DONE. Required: the current frame finishes, `count`=0, and no further `Tx_valid` occurs.
- **Timeout:** `ready` held at 1 after a launch. Required: FSM back in IDLE after 4 cycles, and the next queued byte launches on the following cycle.
- **Async reset mid-burst:** assert `reset` between edges while 3 bytes are queued. Required: all outputs take their reset values immediately, and no launch occurs after release until a new write.
